// File: rtl/uart_lite_port.sv
// uart_lite_port: queues outgoing words and sends them byte by byte into an AXI4-Lite UART Lite,
// polling its status register first. Define UART_PORT_RX_EN to build the word-assembling RX path.
module uart_lite_port #(
    parameter int WORD_BYTES = 4,
    parameter int TX_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*WORD_BYTES-1:0] tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic                    tx_idle,
    output logic [8*WORD_BYTES-1:0] rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic                    err,
    output logic [3:0]              uart_axi_araddr,
    output logic                    uart_axi_arvalid,
    input  logic                    uart_axi_arready,
    input  logic [31:0]             uart_axi_rdata,
    input  logic [1:0]              uart_axi_rresp,
    input  logic                    uart_axi_rvalid,
    output logic                    uart_axi_rready,
    output logic [3:0]              uart_axi_awaddr,
    output logic                    uart_axi_awvalid,
    input  logic                    uart_axi_awready,
    output logic [31:0]             uart_axi_wdata,
    output logic [3:0]              uart_axi_wstrb,
    output logic                    uart_axi_wvalid,
    input  logic                    uart_axi_wready,
    input  logic [1:0]              uart_axi_bresp,
    input  logic                    uart_axi_bvalid,
    output logic                    uart_axi_bready
);
    localparam int W  = 8 * WORD_BYTES;
    localparam int AW = $clog2(TX_DEPTH);
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(WORD_BYTES - 1);
    localparam logic [3:0]    ADDR_RX   = 4'h0;
    localparam logic [3:0]    ADDR_STAT = 4'h8;

    typedef enum logic [2:0] {
        S_IDLE, S_STAT_AR, S_STAT_R, S_WR, S_B, S_RX_AR, S_RX_R
    } state_t;

    state_t        state_q;
    logic [3:0]    araddr_q;
    logic          arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic [31:0]   wdata_q;
    logic          err_q;
    logic          last_tx_q;
    logic [IW-1:0] tx_idx_q;

    // TX FIFO: pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [W-1:0]  fifo_mem_q [TX_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_empty, fifo_full, push, pop;
    logic [W-1:0]  fifo_head;
    logic [7:0]    cur_byte;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = tx_valid && !fifo_full;
    assign pop        = (state_q == S_B) && bready_q && uart_axi_bvalid && (tx_idx_q == LAST_IDX);
    assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign cur_byte   = 8'(fifo_head >> {tx_idx_q, 3'b000});

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    logic can_tx, can_rx, do_tx, do_rx, rx_poll, wr_done, unused_bits;

`ifdef UART_PORT_RX_EN
    logic [W-1:0]  rx_data_q;
    logic          rx_valid_q;
    logic [IW-1:0] rx_idx_q;
    assign can_rx      = uart_axi_rdata[0] && !rx_valid_q;
    assign rx_poll     = !rx_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign unused_bits = ^{uart_axi_rdata[31:8], uart_axi_rdata[2:1]};
`else
    assign can_rx      = 1'b0;
    assign rx_poll     = 1'b0;
    assign rx_data     = '0;
    assign rx_valid    = 1'b0;
    assign unused_bits = ^{uart_axi_rdata[31:4], uart_axi_rdata[2:0], rx_ready};
`endif

    // When both directions are ready, alternate starting from whichever did not go last.
    assign can_tx  = !fifo_empty && !uart_axi_rdata[3];
    assign do_tx   = can_tx && !(can_rx && last_tx_q);
    assign do_rx   = can_rx && !do_tx;
    assign wr_done = (!awvalid_q || uart_axi_awready) && (!wvalid_q || uart_axi_wready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            araddr_q  <= ADDR_STAT;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            last_tx_q <= 1'b0;
            tx_idx_q  <= '0;
`ifdef UART_PORT_RX_EN
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_idx_q   <= '0;
`endif
        end else begin
`ifdef UART_PORT_RX_EN
            if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty || rx_poll) begin
                        araddr_q  <= ADDR_STAT;
                        arvalid_q <= 1'b1;
                        state_q   <= S_STAT_AR;
                    end
                end
                S_STAT_AR: begin
                    if (arvalid_q && uart_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_STAT_R;
                    end
                end
                S_STAT_R: begin
                    if (rready_q && uart_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (uart_axi_rresp != 2'b00) err_q <= 1'b1;
                        if (do_tx) begin
                            wdata_q   <= {24'd0, cur_byte};
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            last_tx_q <= 1'b1;
                            state_q   <= S_WR;
                        end else if (do_rx) begin
                            araddr_q  <= ADDR_RX;
                            arvalid_q <= 1'b1;
                            last_tx_q <= 1'b0;
                            state_q   <= S_RX_AR;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_WR: begin
                    if (uart_axi_awready) awvalid_q <= 1'b0;
                    if (uart_axi_wready)  wvalid_q  <= 1'b0;
                    if (wr_done) begin
                        bready_q <= 1'b1;
                        state_q  <= S_B;
                    end
                end
                S_B: begin
                    if (bready_q && uart_axi_bvalid) begin
                        bready_q <= 1'b0;
                        if (uart_axi_bresp != 2'b00) err_q <= 1'b1;
                        tx_idx_q <= (tx_idx_q == LAST_IDX) ? '0 : tx_idx_q + 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
`ifdef UART_PORT_RX_EN
                S_RX_AR: begin
                    if (arvalid_q && uart_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RX_R;
                    end
                end
                S_RX_R: begin
                    if (rready_q && uart_axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (uart_axi_rresp != 2'b00) err_q <= 1'b1;
                        rx_data_q[8*rx_idx_q +: 8] <= uart_axi_rdata[7:0];
                        if (rx_idx_q == LAST_IDX) begin
                            rx_valid_q <= 1'b1;
                            rx_idx_q   <= '0;
                        end else begin
                            rx_idx_q <= rx_idx_q + 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_ready         = !fifo_full;
    assign tx_idle          = fifo_empty && (state_q == S_IDLE);
    assign err              = err_q;
    assign uart_axi_araddr  = araddr_q;
    assign uart_axi_arvalid = arvalid_q;
    assign uart_axi_rready  = rready_q;
    assign uart_axi_awaddr  = 4'h4;
    assign uart_axi_awvalid = awvalid_q;
    assign uart_axi_wdata   = wdata_q;
    assign uart_axi_wstrb   = 4'b0001;
    assign uart_axi_wvalid  = wvalid_q;
    assign uart_axi_bready  = bready_q;
endmodule

// File: tb/tb_uart_lite_port.sv
// Self-checking bench for uart_lite_port: behavioural AXI4-Lite UART Lite slave plus
// a byte-stream reference model; RX scenarios are built when UART_PORT_RX_EN is defined.
`timescale 1ns/1ps
module tb_uart_lite_port;
  localparam int WB    = 4;
  localparam int W     = 8 * WB;
  localparam int DEPTH = 16;

  logic          clk, rst;
  logic [W-1:0]  tx_data, rx_data;
  logic          tx_valid, tx_ready, tx_idle, rx_valid, rx_ready, err;
  logic [3:0]    uart_axi_araddr, uart_axi_awaddr, uart_axi_wstrb;
  logic          uart_axi_arvalid, uart_axi_arready, uart_axi_rvalid, uart_axi_rready;
  logic [31:0]   uart_axi_rdata, uart_axi_wdata;
  logic [1:0]    uart_axi_rresp, uart_axi_bresp;
  logic          uart_axi_awvalid, uart_axi_awready, uart_axi_wvalid, uart_axi_wready;
  logic          uart_axi_bvalid, uart_axi_bready;

  uart_lite_port #(.WORD_BYTES(WB), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_idle(tx_idle),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .err(err),
    .uart_axi_araddr(uart_axi_araddr), .uart_axi_arvalid(uart_axi_arvalid),
    .uart_axi_arready(uart_axi_arready), .uart_axi_rdata(uart_axi_rdata),
    .uart_axi_rresp(uart_axi_rresp), .uart_axi_rvalid(uart_axi_rvalid),
    .uart_axi_rready(uart_axi_rready), .uart_axi_awaddr(uart_axi_awaddr),
    .uart_axi_awvalid(uart_axi_awvalid), .uart_axi_awready(uart_axi_awready),
    .uart_axi_wdata(uart_axi_wdata), .uart_axi_wstrb(uart_axi_wstrb),
    .uart_axi_wvalid(uart_axi_wvalid), .uart_axi_wready(uart_axi_wready),
    .uart_axi_bresp(uart_axi_bresp), .uart_axi_bvalid(uart_axi_bvalid),
    .uart_axi_bready(uart_axi_bready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] rx_src_q[$];
  bit         xfer_log[$];

  // slave controls, written only by the stimulus process
  bit stall_wr   = 1'b0;
  bit rand_ready = 1'b0;
  bit stat_rx    = 1'b0;
  int full_base  = 0;
  int full_polls = 0;
  int err_write_idx = -1;

  // slave statistics, written only by the slave process
  int stat_reads = 0;
  int rx_reads   = 0;
  int tx_writes  = 0;
  int bad_cnt    = 0;

  // ---------------- behavioural AXI4-Lite UART Lite slave ----------------
  logic        aw_got, w_got;
  logic [3:0]  aw_addr_q, w_strb_q;
  logic [31:0] w_data_q;
  wire         ar_hs      = uart_axi_arvalid && uart_axi_arready;
  wire         aw_hs      = uart_axi_awvalid && uart_axi_awready;
  wire         w_hs       = uart_axi_wvalid && uart_axi_wready;
  wire         aw_done    = aw_got || aw_hs;
  wire         w_done     = w_got || w_hs;
  wire [3:0]   aw_addr_c  = aw_got ? aw_addr_q : uart_axi_awaddr;
  wire [3:0]   w_strb_c   = w_got ? w_strb_q : uart_axi_wstrb;
  wire [31:0]  w_data_c   = w_got ? w_data_q : uart_axi_wdata;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      uart_axi_arready <= 1'b0; uart_axi_rvalid <= 1'b0; uart_axi_rdata <= '0;
      uart_axi_rresp   <= 2'b00; uart_axi_awready <= 1'b0; uart_axi_wready <= 1'b0;
      uart_axi_bvalid  <= 1'b0; uart_axi_bresp <= 2'b00;
      aw_got <= 1'b0; w_got <= 1'b0; aw_addr_q <= '0; w_strb_q <= '0; w_data_q <= '0;
    end else begin
      uart_axi_arready <= rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      uart_axi_awready <= stall_wr ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      uart_axi_wready  <= stall_wr ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      if (uart_axi_rvalid && uart_axi_rready) uart_axi_rvalid <= 1'b0;
      if (uart_axi_bvalid && uart_axi_bready) uart_axi_bvalid <= 1'b0;
      if (ar_hs) begin
        uart_axi_rvalid <= 1'b1;
        uart_axi_rresp  <= 2'b00;
        if (uart_axi_araddr == 4'h8) begin
          uart_axi_rdata <= {28'd0, ((stat_reads - full_base) < full_polls), 2'b00, stat_rx};
          stat_reads     <= stat_reads + 1;
        end else begin
          if (uart_axi_araddr != 4'h0) bad_cnt <= bad_cnt + 1;
          rx_reads <= rx_reads + 1;
          xfer_log.push_back(1'b1);
          uart_axi_rdata <= (rx_src_q.size() > 0) ? {24'd0, rx_src_q.pop_front()} : 32'd0;
        end
      end
      if (aw_done && w_done) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        uart_axi_bvalid <= 1'b1;
        uart_axi_bresp  <= (tx_writes == err_write_idx) ? 2'b10 : 2'b00;
        tx_writes <= tx_writes + 1;
        obs_q.push_back(w_data_c[7:0]);
        xfer_log.push_back(1'b0);
        if (aw_addr_c != 4'h4 || w_strb_c != 4'b0001 || w_data_c[31:8] != 24'd0)
          bad_cnt <= bad_cnt + 1;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= uart_axi_awaddr; end
        if (w_hs) begin w_got <= 1'b1; w_strb_q <= uart_axi_wstrb; w_data_q <= uart_axi_wdata; end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    stall_wr = 1'b0; rand_ready = 1'b0; stat_rx = 1'b0;
    full_polls = 0; err_write_idx = -1;
    repeat (3) @(posedge clk);
    exp_q.delete(); obs_q.delete(); rx_src_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] w, output bit acc);
    @(negedge clk);
    tx_data = w; tx_valid = 1'b1; acc = tx_ready;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic model_word(input logic [W-1:0] w);
    for (int i = 0; i < WB; i++) exp_q.push_back(8'((w >> (8 * i)) & 'hFF));
  endtask

  task automatic wait_idle(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); cyc++;
      @(negedge clk);
    end while (!tx_idle && cyc < max_cyc);
    if (!tx_idle) cyc = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    @(negedge clk);
    n_cmp++; if ({uart_axi_arvalid, uart_axi_rready, uart_axi_awvalid, uart_axi_wvalid, uart_axi_bready} !== 5'b0) begin
      n_bad++; $display("FAIL reset_valids got %b exp 00000", {uart_axi_arvalid, uart_axi_rready, uart_axi_awvalid, uart_axi_wvalid, uart_axi_bready}); end
    n_cmp++; if (uart_axi_araddr !== 4'h8) begin n_bad++; $display("FAIL reset_araddr got %h exp 8", uart_axi_araddr); end
    n_cmp++; if (uart_axi_awaddr !== 4'h4) begin n_bad++; $display("FAIL reset_awaddr got %h exp 4", uart_axi_awaddr); end
    n_cmp++; if (uart_axi_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wdata got %h exp 0", uart_axi_wdata); end
    n_cmp++; if (uart_axi_wstrb !== 4'b0001) begin n_bad++; $display("FAIL reset_wstrb got %b exp 0001", uart_axi_wstrb); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL reset_tx_idle got %b exp 1", tx_idle); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
`ifndef UART_PORT_RX_EN
    begin
      int s0;
      s0 = stat_reads;
      repeat (30) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (stat_reads != s0) begin n_bad++; $display("FAIL idle_no_poll got %0d reads exp 0", stat_reads - s0); end
      n_cmp++; if (rx_data !== '0) begin n_bad++; $display("FAIL rx_data_tied got %h exp 0", rx_data); end
    end
`endif
  endtask

  task automatic test_single_word();
    bit acc; int cyc; logic [7:0] e, o;
    reset_dut();
    push_word(32'h44332211, acc);
    model_word(32'h44332211);
    n_cmp++; if (!acc) begin n_bad++; $display("FAIL single_accept got 0 exp 1"); end
    wait_idle(500, cyc);
`ifndef UART_PORT_RX_EN
    n_cmp++; if (cyc != 20) begin n_bad++; $display("FAIL single_cycles got %0d exp 20", cyc); end
`endif
    n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL single_idle got %b exp 1", tx_idle); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL single_byte got %h exp %h", o, e); end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL single_extra got %0d extra writes exp 0", obs_q.size()); end
  endtask

  task automatic test_full_status();
    bit acc; int cyc, s0, w0, t; logic [7:0] e, o;
    reset_dut();
    s0 = stat_reads; w0 = tx_writes;
    full_base = s0; full_polls = 3;
    push_word(32'hA5B6C7D8, acc);
    model_word(32'hA5B6C7D8);
    t = 0;
    while (tx_writes == w0 && t < 300) begin @(negedge clk); t++; end
    n_cmp++; if (stat_reads - s0 != 4) begin n_bad++; $display("FAIL busy_first_write got %0d status reads exp 4", stat_reads - s0); end
    wait_idle(500, cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL busy_idle_timeout got timeout exp idle"); end
    n_cmp++; if (tx_writes - w0 != 4) begin n_bad++; $display("FAIL busy_writes got %0d exp 4", tx_writes - w0); end
`ifndef UART_PORT_RX_EN
    n_cmp++; if (stat_reads - s0 != 7) begin n_bad++; $display("FAIL busy_total_polls got %0d exp 7", stat_reads - s0); end
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL busy_byte got %h exp %h", o, e); end
    end
  endtask

  task automatic test_fifo_full();
    bit acc; int n_acc, cyc, w0, t; logic [W-1:0] w; logic [7:0] e, o;
    reset_dut();
    stall_wr = 1'b1;
    w0 = tx_writes; n_acc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = W'($urandom);
      push_word(w, acc);
      if (acc) begin n_acc++; model_word(w); end
    end
    n_cmp++; if (n_acc != DEPTH) begin n_bad++; $display("FAIL full_accepts got %0d exp %0d", n_acc, DEPTH); end
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL full_tx_ready got %b exp 0", tx_ready); end
    w = W'($urandom);
    tx_data = w; tx_valid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold_ready got %b exp 0", tx_ready); end
    stall_wr = 1'b0;
    t = 0;
    while (!tx_ready && t < 300) begin @(negedge clk); t++; end
    n_cmp++; if (tx_writes - w0 != WB) begin n_bad++; $display("FAIL full_accept_after_pop got %0d writes exp %0d", tx_writes - w0, WB); end
    @(posedge clk);
    #1 tx_valid = 1'b0;
    model_word(w);
    rand_ready = 1'b1;
    wait_idle(5000, cyc);
    n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL full_idle_timeout got timeout exp idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL full_byte got %h exp %h", o, e); end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL full_extra got %0d extra writes exp 0", obs_q.size()); end
  endtask

  task automatic test_random();
    bit acc; int cyc, nw; logic [W-1:0] w; logic [7:0] e, o;
    reset_dut();
    rand_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      full_base = stat_reads; full_polls = $urandom_range(0, 3);
      nw = $urandom_range(1, 5);
      for (int i = 0; i < nw; i++) begin
        w = W'($urandom);
        push_word(w, acc);
        n_cmp++; if (!acc) begin n_bad++; $display("FAIL rand_accept got 0 exp 1"); end
        if (acc) model_word(w);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      wait_idle(3000, cyc);
      n_cmp++; if (cyc < 0) begin n_bad++; $display("FAIL rand_idle_timeout got timeout exp idle"); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
        n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rand_byte got %h exp %h", o, e); end
      end
    end
    n_cmp++; if (bad_cnt != 0) begin n_bad++; $display("FAIL axi_fields got %0d bad accesses exp 0", bad_cnt); end
  endtask

  task automatic test_err();
    bit acc; int cyc, w0; logic [7:0] e, o;
    reset_dut();
    w0 = tx_writes;
    err_write_idx = tx_writes + 1;
    push_word(32'h0F1E2D3C, acc);
    model_word(32'h0F1E2D3C);
    wait_idle(500, cyc);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got %b exp 1", err); end
    n_cmp++; if (tx_writes - w0 != 4) begin n_bad++; $display("FAIL err_no_retry got %0d writes exp 4", tx_writes - w0); end
    push_word(32'h55667788, acc);
    model_word(32'h55667788);
    wait_idle(500, cyc);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b exp 1", err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 8'hxx;
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL err_byte got %h exp %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_wr();
    bit acc; int t;
    stall_wr = 1'b1;
    push_word(32'hDEADBEEF, acc);
    push_word(32'h12345678, acc);
    t = 0;
    while (!uart_axi_awvalid && t < 200) begin @(negedge clk); t++; end
    n_cmp++; if (uart_axi_awvalid !== 1'b1) begin n_bad++; $display("FAIL midwr_reach got awvalid %b exp 1", uart_axi_awvalid); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({uart_axi_arvalid, uart_axi_rready, uart_axi_awvalid, uart_axi_wvalid, uart_axi_bready} !== 5'b0) begin
      n_bad++; $display("FAIL midwr_valids got %b exp 00000", {uart_axi_arvalid, uart_axi_rready, uart_axi_awvalid, uart_axi_wvalid, uart_axi_bready}); end
    n_cmp++; if (tx_idle !== 1'b1 || tx_ready !== 1'b1) begin n_bad++; $display("FAIL midwr_fifo got idle %b ready %b exp 1 1", tx_idle, tx_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL midwr_err got %b exp 0", err); end
    reset_dut();
  endtask

`ifdef UART_PORT_RX_EN
  task automatic test_rx();
    logic [7:0] b[4]; logic [W-1:0] exp_w; int r0, t;
    reset_dut();
    b[0] = 8'hAA; b[1] = 8'hBB; b[2] = 8'hCC; b[3] = 8'hDD;
    exp_w = '0;
    for (int i = 0; i < 4; i++) begin
      rx_src_q.push_back(b[i]);
      exp_w = exp_w + (W'(b[i]) << (8 * i));
    end
    r0 = rx_reads;
    stat_rx = 1'b1;
    t = 0;
    while (!rx_valid && t < 300) begin @(negedge clk); t++; end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx_valid got %b exp 1", rx_valid); end
    n_cmp++; if (rx_data !== exp_w) begin n_bad++; $display("FAIL rx_data got %h exp %h", rx_data, exp_w); end
    repeat (30) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rx_reads - r0 != 4) begin n_bad++; $display("FAIL rx_no_extra_reads got %0d exp 4", rx_reads - r0); end
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== exp_w) begin n_bad++; $display("FAIL rx_hold got %b/%h exp 1/%h", rx_valid, rx_data, exp_w); end
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    stat_rx = 1'b0;
    @(negedge clk);
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rx_consume got %b exp 0", rx_valid); end
  endtask

  task automatic test_alternate();
    bit acc; int w0, base, t; bit exp_k;
    reset_dut();
    rx_ready = 1'b1;
    w0 = tx_writes;
    base = xfer_log.size();
    push_word(32'h04030201, acc);
    stat_rx = 1'b1;
    t = 0;
    while (tx_writes - w0 < 4 && t < 500) begin @(negedge clk); t++; end
    for (int i = 0; i < 8; i++) begin
      exp_k = (i % 2) == 1;
      n_cmp++;
      if (xfer_log.size() <= base + i || xfer_log[base + i] !== exp_k) begin
        n_bad++; $display("FAIL alt_order idx %0d got %0b exp %0b", i,
          (xfer_log.size() > base + i) ? xfer_log[base + i] : 1'bx, exp_k);
      end
    end
    stat_rx = 1'b0;
    rx_ready = 1'b0;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_word();
    test_full_status();
    test_fifo_full();
    test_random();
    test_err();
    test_reset_mid_wr();
`ifdef UART_PORT_RX_EN
    test_rx();
    test_alternate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
